// File: rtl/sw_pkg.sv
// Shared constants and FSM encoding for the switch debouncer and its synchronizer.
package sw_pkg;
  localparam int SW_WIDTH      = 3;
  localparam int DB_CYCLES_DEF = 500000;
  localparam int CHG_CNT_W     = 8;

  typedef enum logic {
    ST_IDLE,
    ST_COUNT
  } state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (switches, push-buttons).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/sw_debounce.sv
// Synchronizes and debounces a switch vector as one unit; emits a 1-cycle strobe per accepted code.
// Optional macro SW_CHG_CNT_EN adds an 8-bit accepted-change counter port chg_cnt.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH     = SW_WIDTH,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_chg
`ifdef SW_CHG_CNT_EN
  ,
  output logic [CHG_CNT_W-1:0] chg_cnt
`endif
);
  localparam int             CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s2;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic             chg_q, chg_d;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (s2)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (s2 != cand_q) state_d = ST_COUNT;
      ST_COUNT: begin
        // A bounce back to the accepted code abandons the window silently.
        if (s2 != cand_q)          state_d = (s2 == stable_q) ? ST_IDLE : ST_COUNT;
        else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    chg_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s2 != cand_q) cand_d = s2;
      end
      ST_COUNT: begin
        if (s2 != cand_q) begin
          cand_d = s2;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = cand_q;
          chg_d    = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      chg_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      chg_q    <= chg_d;
    end
  end

  assign sw_stable = stable_q;
  assign sw_chg    = chg_q;

`ifdef SW_CHG_CNT_EN
  logic [CHG_CNT_W-1:0] chg_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)        chg_cnt_q <= '0;
    else if (chg_q) chg_cnt_q <= chg_cnt_q + 1'b1;
  end

  assign chg_cnt = chg_cnt_q;
`endif
endmodule
